// File: rtl/key_lookup_unit.sv
// key_lookup_unit: sequential key search over a one-hot-read entry store.
// Reports hit, one-hot hit index, lowest free slot and full flag.
module key_lookup_unit #(
    parameter int NUM_ENTRIES = 16,
    parameter int KEY_WIDTH   = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [KEY_WIDTH-1:0]   key_in,
    input  logic [NUM_ENTRIES-1:0] used_in,
    output logic [NUM_ENTRIES-1:0] rd_sel,
    input  logic [KEY_WIDTH-1:0]   rd_key,
    output logic                   busy,
    output logic                   done,
    output logic                   hit,
    output logic [NUM_ENTRIES-1:0] hit_idx,
    output logic [NUM_ENTRIES-1:0] free_idx,
    output logic                   full
);

    localparam int CW = $clog2(NUM_ENTRIES);
    localparam logic [CW-1:0] LAST = CW'(NUM_ENTRIES - 1);
    localparam logic [NUM_ENTRIES-1:0] ONE = NUM_ENTRIES'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [KEY_WIDTH-1:0]   key_q, key_d;
    logic [NUM_ENTRIES-1:0] used_q, used_d;
    logic                   hit_q, hit_d;
    logic [NUM_ENTRIES-1:0] hit_idx_q, hit_idx_d;
    logic [NUM_ENTRIES-1:0] free_q, free_d;
    logic                   full_q, full_d;

    logic [NUM_ENTRIES-1:0] used_inc;
    logic [NUM_ENTRIES-1:0] lowest_free;
    logic                   match;
    logic                   last;

    // Lowest zero of used_in as one-hot; the increment wraps to 0 when full.
    assign used_inc    = used_in + ONE;
    assign lowest_free = ~used_in & used_inc;

    // Unused entries never match, whatever the store returns.
    assign match = (state_q == SCAN) && used_q[cnt_q] && (rd_key == key_q);
    assign last  = (cnt_q == LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort outranks a match in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = SCAN;
            SCAN: begin
                if (abort)              state_d = IDLE;
                else if (match || last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; abort suppresses the done pulse.
    always_comb begin
        rd_sel = '0;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (state_q)
            IDLE: ;
            SCAN: begin
                rd_sel = ONE << cnt_q;
                busy   = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = !abort;
            end
            default: ;
        endcase
    end

    // Datapath next values: request latch, scan counter, result regs.
    always_comb begin
        cnt_d     = cnt_q;
        key_d     = key_q;
        used_d    = used_q;
        hit_d     = hit_q;
        hit_idx_d = hit_idx_q;
        free_d    = free_q;
        full_d    = full_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    key_d     = key_in;
                    used_d    = used_in;
                    cnt_d     = '0;
                    hit_d     = 1'b0;
                    hit_idx_d = '0;
                    free_d    = lowest_free;
                    full_d    = &used_in;
                end
            end
            SCAN: begin
                if (abort) begin
                    cnt_d     = '0;
                    hit_d     = 1'b0;
                    hit_idx_d = '0;
                    free_d    = '0;
                    full_d    = 1'b0;
                end else if (match) begin
                    hit_d     = 1'b1;
                    hit_idx_d = ONE << cnt_q;
                end else if (!last) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (abort) begin
                    hit_d     = 1'b0;
                    hit_idx_d = '0;
                    free_d    = '0;
                    full_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            key_q     <= '0;
            used_q    <= '0;
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
            free_q    <= '0;
            full_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            key_q     <= key_d;
            used_q    <= used_d;
            hit_q     <= hit_d;
            hit_idx_q <= hit_idx_d;
            free_q    <= free_d;
            full_q    <= full_d;
        end
    end

    assign hit      = hit_q;
    assign hit_idx  = hit_idx_q;
    assign free_idx = free_q;
    assign full     = full_q;

endmodule
